// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap controller sequencing CSR writes, PC redirect and pipeline flush
module trap_sequencer #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_inst_addr,
  input  logic             i_ex_illegal,
  input  logic             i_ex_ebreak,
  input  logic             i_ex_ecall,
  input  logic             i_ex_st_addr,
  input  logic             i_ex_ld_addr,
  input  logic             i_mret,
  input  logic [XLEN-1:0]  i_PC,
  input  logic [XLEN-1:0]  i_badaddr,
  input  logic [XLEN-1:0]  i_tvec,
  input  logic [XLEN-1:0]  i_epc,
  output logic             o_csr_we,
  output logic [XLEN-1:0]  o_cause,
  output logic [XLEN-1:0]  o_epc,
  output logic [XLEN-1:0]  o_tval,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_target,
  output logic             o_flush,
  output logic             o_stall,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_trap_cnt
);
  localparam int FW = FLUSH_CYCLES > 2 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WRITE, REDIRECT, FLUSH} state_t;
  state_t state;
  logic mret_mode;
  logic [FW-1:0] fcnt;
  logic [XLEN-1:0] cause, epc, tval, target, cause_n, tval_n;
  logic [CNT_W-1:0] trap_cnt;
  logic any_ex;
  assign any_ex = |{i_ex_inst_addr, i_ex_illegal, i_ex_ebreak, i_ex_ecall, i_ex_st_addr, i_ex_ld_addr};
  always_comb begin
    cause_n = i_ex_inst_addr ? XLEN'(0) : i_ex_illegal ? XLEN'(2) : i_ex_ebreak ? XLEN'(3) :
              i_ex_ecall ? XLEN'(11) : i_ex_st_addr ? XLEN'(6) : XLEN'(4);
    tval_n  = (cause_n == XLEN'(0) || cause_n == XLEN'(4) || cause_n == XLEN'(6)) ? i_badaddr : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state     <= IDLE;
      mret_mode <= 1'b0;
      fcnt      <= '0;
      cause     <= '0;
      epc       <= '0;
      tval      <= '0;
      target    <= '0;
      trap_cnt  <= '0;
    end else
      case (state)
        IDLE:
          if (any_ex) begin
            cause     <= cause_n;
            epc       <= i_PC & ~XLEN'(3);
            tval      <= tval_n;
            mret_mode <= 1'b0;
            state     <= WRITE;
          end else if (i_mret) begin
            target    <= i_epc;
            mret_mode <= 1'b1;
            state     <= REDIRECT;
          end
        // mtvec is taken as it stands during the CSR write cycle
        WRITE: begin
          target <= i_tvec;
          state  <= REDIRECT;
        end
        REDIRECT: begin
          if (!mret_mode) trap_cnt <= trap_cnt + CNT_W'(1);
          fcnt  <= FW'(FLUSH_CYCLES - 2);
          state <= FLUSH_CYCLES > 1 ? FLUSH : IDLE;
        end
        FLUSH: begin
          fcnt  <= fcnt - FW'(1);
          state <= fcnt == '0 ? IDLE : FLUSH;
        end
        default: state <= IDLE;
      endcase
  assign o_csr_we   = state == WRITE;
  assign o_redirect = state == REDIRECT;
  assign o_flush    = state == REDIRECT || state == FLUSH;
  assign o_busy     = state != IDLE;
  assign o_stall    = o_busy || any_ex || i_mret;
  assign o_cause    = cause;
  assign o_epc      = epc;
  assign o_tval     = tval;
  assign o_target   = target;
  assign o_trap_cnt = trap_cnt;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: randomized and directed checks of trap_sequencer against a timeline model
module tb_trap_sequencer;
  localparam int FC = 2;
  localparam int CW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] req = '0;
  logic [31:0] pc = '0, bad = '0, tvec = '0, epc_in = '0;
  logic csr_we, redirect, flush, stall, busy;
  logic [31:0] cause, epc, tval, target;
  logic [CW-1:0] trap_cnt;
  int vectors = 0, miscompares = 0;
  bit m_act, m_mret;
  int m_d, m_cnt;
  logic [31:0] m_cause, m_epc, m_tval, m_tgt;
  int pri_bit[6]  = '{6, 5, 4, 3, 2, 1};
  int pri_code[6] = '{0, 2, 3, 11, 6, 4};
  always #5 clk = ~clk;
  trap_sequencer #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ex_inst_addr(req[6]), .i_ex_illegal(req[5]), .i_ex_ebreak(req[4]), .i_ex_ecall(req[3]),
    .i_ex_st_addr(req[2]), .i_ex_ld_addr(req[1]), .i_mret(req[0]),
    .i_PC(pc), .i_badaddr(bad), .i_tvec(tvec), .i_epc(epc_in),
    .o_csr_we(csr_we), .o_cause(cause), .o_epc(epc), .o_tval(tval),
    .o_redirect(redirect), .o_target(target), .o_flush(flush), .o_stall(stall),
    .o_busy(busy), .o_trap_cnt(trap_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_act = 0; m_mret = 0; m_d = 0; m_cnt = 0;
    m_cause = '0; m_epc = '0; m_tval = '0; m_tgt = '0;
  endtask
  // m_d counts intervals since the request edge; the rest follows from the documented latencies
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_act) begin
      if (!m_mret && m_d == 0) m_tgt = tvec;
      if (!m_mret && m_d == 1) m_cnt = (m_cnt + 1) % (1 << CW);
      m_d++;
      if (m_d > (m_mret ? FC - 1 : FC)) m_act = 0;
    end else if (|req[6:1]) begin
      for (int i = 5; i >= 0; i--)
        if (req[pri_bit[i]]) m_cause = pri_code[i];
      m_epc  = {pc[31:2], 2'b00};
      m_tval = (m_cause == 0 || m_cause == 4 || m_cause == 6) ? bad : 32'h0;
      m_act = 1; m_mret = 0; m_d = 0;
    end else if (req[0]) begin
      m_tgt = epc_in;
      m_act = 1; m_mret = 1; m_d = 0;
    end
  endtask
  task automatic compare_all();
    int r0;
    bit e_rd;
    r0   = m_mret ? 0 : 1;
    e_rd = m_act && m_d == r0;
    chk("csr_we", 32'(csr_we), 32'(m_act && !m_mret && m_d == 0));
    chk("redirect", 32'(redirect), 32'(e_rd));
    chk("flush", 32'(flush), 32'(m_act && m_d >= r0 && m_d < r0 + FC));
    chk("busy", 32'(busy), 32'(m_act));
    chk("stall", 32'(stall), 32'(m_act || (|req)));
    chk("cause", cause, m_cause);
    chk("epc", epc, m_epc);
    chk("tval", tval, m_tval);
    chk("trap_cnt", 32'(trap_cnt), 32'(m_cnt));
    if (e_rd || !rst_n) chk("target", target, m_tgt);
  endtask
  task automatic drive(input logic [6:0] r, input logic [31:0] p, b, t, e);
    @(negedge clk);
    req = r; pc = p; bad = b; tvec = t; epc_in = e;
    #1 compare_all();
  endtask
  task automatic edge_();
    @(posedge clk);
    model_edge();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive('0, 0, 0, 32'h900, 0);
      edge_();
    end
  endtask
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 compare_all();
    edge_();
  endtask
  initial begin
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive('0, 0, 0, 0, 0);
      edge_();
    end
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(trap_cnt), 0);
    chk("rst_flush", 32'(flush), 0);
    release_reset();
    // load misaligned
    drive(7'b0000010, 32'h100, 32'h203, 32'h800, 0);
    chk("ld_stall", 32'(stall), 1);
    chk("ld_busy0", 32'(busy), 0);
    edge_();
    drive('0, 0, 0, 32'h800, 0);
    chk("ld_we", 32'(csr_we), 1);
    chk("ld_cause", cause, 32'h4);
    chk("ld_epc", epc, 32'h100);
    chk("ld_tval", tval, 32'h203);
    edge_();
    drive('0, 0, 0, 32'h999, 0);
    chk("ld_redirect", 32'(redirect), 1);
    chk("ld_target", target, 32'h800);
    chk("ld_flush1", 32'(flush), 1);
    edge_();
    drive('0, 0, 0, 0, 0);
    chk("ld_flush2", 32'(flush), 1);
    chk("ld_cnt", 32'(trap_cnt), 1);
    edge_();
    drive('0, 0, 0, 0, 0);
    chk("ld_done", 32'(flush | busy), 0);
    edge_();
    // simultaneous illegal/ecall/store
    drive(7'b0101100, 32'h207, 32'h55, 32'h900, 0);
    edge_();
    drive('0, 0, 0, 32'h900, 0);
    chk("pri_cause", cause, 32'h2);
    chk("pri_tval", tval, 32'h0);
    chk("pri_epc", epc, 32'h204);
    edge_();
    idle(3);
    // mret alone, then mret with ebreak
    drive(7'b0000001, 0, 0, 32'hA00, 32'h444);
    edge_();
    drive('0, 0, 0, 32'hA00, 0);
    chk("mret_redirect", 32'(redirect), 1);
    chk("mret_target", target, 32'h444);
    chk("mret_we", 32'(csr_we), 0);
    edge_();
    idle(2);
    chk("mret_cnt", 32'(trap_cnt), 2);
    chk("mret_cause_hold", cause, 32'h2);
    drive(7'b0010001, 32'h50, 32'h77, 32'hA00, 32'h444);
    edge_();
    drive('0, 0, 0, 32'hA00, 0);
    chk("eb_cause", cause, 32'h3);
    edge_();
    drive('0, 0, 0, 0, 0);
    chk("eb_target", target, 32'hA00);
    edge_();
    idle(2);
    // ecall while busy is dropped; fourth trap wraps the 2-bit counter
    drive(7'b0000010, 32'h600, 32'h601, 32'hB00, 0);
    edge_();
    drive(7'b0001000, 32'h700, 0, 32'hB00, 0);
    chk("busy_stall", 32'(stall), 1);
    edge_();
    drive(7'b0001000, 32'h700, 0, 32'hB00, 0);
    edge_();
    idle(3);
    chk("busy_cause", cause, 32'h4);
    chk("wrap_cnt", 32'(trap_cnt), 0);
    drive(7'b1000000, 32'h123, 32'h456, 32'hC00, 0);
    edge_();
    idle(4);
    chk("cnt_after_wrap", 32'(trap_cnt), 1);
    chk("ia_tval", tval, 32'h456);
    // asynchronous reset during REDIRECT
    drive(7'b0000100, 32'h300, 32'h7, 32'h1000, 0);
    edge_();
    drive('0, 0, 0, 32'h1000, 0);
    edge_();
    drive('0, 0, 0, 0, 0);
    chk("mid_redirect", 32'(redirect), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_redirect", 32'(redirect), 0);
    chk("mid_rst_flush", 32'(flush), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt", 32'(trap_cnt), 0);
    chk("mid_rst_cause", cause, 0);
    chk("mid_rst_target", target, 0);
    model_reset();
    compare_all();
    edge_();
    drive('0, 0, 0, 0, 0);
    edge_();
    release_reset();
    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [6:0] r;
      for (int k = 1; k < 7; k++) r[k] = $urandom_range(0, 11) == 0;
      r[0] = $urandom_range(0, 5) == 0;
      drive(r, $urandom, $urandom, $urandom, $urandom);
      edge_();
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap controller between the main control/datapath and the CSR file.
- Collects exception requests and MRET, and picks one by fixed priority.
- Over a fixed multi-cycle sequence it writes mcause/mepc/mtval into the CSR file, redirects the PC to mtvec (or mepc on MRET), and holds the pipeline in stall/flush.
- Also counts taken traps for debug.

Parameters:
XLEN, 32, data/address width
FLUSH_CYCLES, 2, cycles o_flush stays high after redirect (>=1)
CNT_W, 16, width of taken-trap counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_ex_inst_addr  in  1  instruction address misaligned request
i_ex_illegal  in  1  illegal instruction request
i_ex_ebreak  in  1  EBREAK request
i_ex_ecall  in  1  ECALL request
i_ex_st_addr  in  1  store address misaligned request
i_ex_ld_addr  in  1  load address misaligned request
i_mret  in  1  MRET request
i_PC  in  XLEN  PC of the faulting/current instruction
i_badaddr  in  XLEN  faulting address
i_tvec  in  XLEN  current mtvec from the CSR file
i_epc  in  XLEN  current mepc from the CSR file
o_csr_we  out  1  one-cycle strobe: write o_cause/o_epc/o_tval into the CSR file
o_cause  out  XLEN  latched cause code
o_epc  out  XLEN  latched PC, low 2 bits forced to 0
o_tval  out  XLEN  latched trap value
o_redirect  out  1  one-cycle PC redirect strobe
o_target  out  XLEN  redirect target, valid while o_redirect=1
o_flush  out  1  flush pipeline registers
o_stall  out  1  freeze PC/pipeline
o_busy  out  1  FSM not in IDLE
o_trap_cnt  out  CNT_W  taken-trap count, wraps

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - State goes to IDLE.
  - All registered outputs, latches and the counter clear to 0.
  - Takes effect immediately, including mid-sequence; no CSR write or redirect completes afterwards.
- Priority (highest first) and cause codes:
  - inst_addr=0, illegal=2, ebreak=3, ecall=11, st_addr=6, ld_addr=4.
  - Any exception beats MRET.
- tval rule: i_badaddr for causes 0/4/6, otherwise 0.
- States: IDLE, WRITE, REDIRECT, FLUSH.
- IDLE:
  - o_stall is combinationally high in the same cycle any request input is high.
  - Exception pending at a clock edge: latch cause, epc={i_PC[XLEN-1:2],2'b00} and tval; go to WRITE.
  - Else i_mret at the edge: latch target=i_epc; go to REDIRECT in MRET mode.
- WRITE (exceptions only):
  - o_csr_we=1 for exactly this cycle with the latched values.
  - o_stall=1.
  - Latch target=i_tvec at the end of this cycle, so the same-cycle mtvec value is used.
  - Go to REDIRECT.
- REDIRECT:
  - o_redirect=1, o_target=latched target, o_flush=1, o_stall=1.
  - Exception mode only: o_trap_cnt increments by 1, modulo 2^CNT_W.
  - Go to FLUSH.
- FLUSH:
  - o_flush=1 and o_stall=1 for FLUSH_CYCLES-1 cycles (a down-counter); skipped when FLUSH_CYCLES=1.
  - Then IDLE.
- Latency:
  - Exception sampled at edge N: o_csr_we in cycle N+1, o_redirect in N+2, o_flush high for cycles N+2 .. N+1+FLUSH_CYCLES.
  - MRET: o_redirect in N+1.
- Requests while o_busy=1 are ignored (not queued); the pipeline is stalled, so the source re-asserts if still valid.
- Simultaneous exceptions: only the highest-priority one is taken; the rest are dropped.
- o_cause/o_epc/o_tval hold their last latched values between traps.
- MRET never asserts o_csr_we and never updates o_cause/o_epc/o_tval.
- o_busy=1 in every state except IDLE.

Test Plan:
- Reset: i_rst_n=0 for 2 cycles -> all outputs 0, o_trap_cnt=0, state IDLE.
- Single load misalign: i_ex_ld_addr=1, i_PC=0x100, i_badaddr=0x203, i_tvec=0x800 -> o_csr_we in cycle+1 with cause=4, epc=0x100, tval=0x203; o_redirect in cycle+2 with target 0x800; o_flush high for 2 cycles; o_trap_cnt=1.
- Priority: i_ex_illegal, i_ex_ecall and i_ex_st_addr together with i_badaddr=0x55 -> cause=2, tval=0; only one o_csr_we.
- MRET: i_mret=1, i_epc=0x444, no exception -> o_redirect next cycle with target 0x444; no o_csr_we; o_trap_cnt unchanged. Same request with i_ex_ebreak=1 -> cause=3 and target=i_tvec instead.
- Busy/ignore: assert i_ex_ecall while in WRITE state -> no second trap; exactly one o_csr_we.
- Reset mid-sequence: drop i_rst_n in REDIRECT -> outputs 0 immediately, o_trap_cnt=0. With CNT_W=2, 4 traps -> o_trap_cnt wraps to 0.
